// File: rtl/gf4_inv_arbiter.sv
// gf4_inv_arbiter: one combinational GF((2^2)^2) nibble inverter shared by
// NUM_REQ requesters via round-robin arbitration. The datapath is a two-stage
// valid/ready pipeline: S1 holds the granted operand and S2 holds the result
// that drives the response port. Nibbles use the normal-basis encoding of the
// S-box datapath: the high pair holds the Z^4 coefficient and the low pair the
// Z coefficient. Each pair encodes an element of GF(4) as {W^2, W}.
module gf4_inv_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [4*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   rsp_valid,
    output logic [3:0]             rsp_data,
    output logic [ID_W-1:0]        rsp_id,
    input  logic                   rsp_ready,
    output logic                   busy,
    output logic [CNT_W-1:0]       op_count
);

    // GF(4) multiply in the {W^2, W} normal basis.
    function automatic logic [1:0] gf4_mul(input logic [1:0] a, input logic [1:0] b);
        logic e;
        e = (a[1] ^ a[0]) & (b[1] ^ b[0]);
        return {(a[1] & b[1]) ^ e, (a[0] & b[0]) ^ e};
    endfunction

    // Squaring in a normal basis is a swap of the two coordinates; in GF(4)
    // squaring is also the multiplicative inverse.
    function automatic logic [1:0] gf4_sq(input logic [1:0] a);
        return {a[0], a[1]};
    endfunction

    // GF(16) inverse over GF(4), norm constant W^2. Zero maps to zero.
    function automatic logic [3:0] gf16_inv(input logic [3:0] x);
        logic [1:0] g1;
        logic [1:0] g0;
        logic [1:0] theta;
        logic [1:0] theta_inv;
        g1        = x[3:2];
        g0        = x[1:0];
        theta     = gf4_mul(gf4_sq(g1 ^ g0), 2'b10) ^ gf4_mul(g1, g0);
        theta_inv = gf4_sq(theta);
        return {gf4_mul(theta_inv, g0), gf4_mul(theta_inv, g1)};
    endfunction

    logic              s1_valid_r;
    logic [3:0]        s1_data_r;
    logic [ID_W-1:0]   s1_id_r;
    logic              s2_valid_r;
    logic [3:0]        s2_data_r;
    logic [ID_W-1:0]   s2_id_r;
    logic [ID_W-1:0]   rr_ptr_r;
    logic [CNT_W-1:0]  op_count_r;

    logic              adv2_s;
    logic              can_accept_s;
    logic              hi_found_s;
    logic [ID_W-1:0]   hi_idx_s;
    logic              lo_found_s;
    logic [ID_W-1:0]   lo_idx_s;
    logic              grant_found_s;
    logic [ID_W-1:0]   grant_idx_s;
    logic [3:0]        grant_data_s;
    logic              accept_s;
    logic [ID_W-1:0]   rr_next_s;
    logic              rsp_fire_s;
    logic [3:0]        inv_s;

    assign adv2_s       = s1_valid_r & (~s2_valid_r | rsp_ready);
    assign can_accept_s = ~s1_valid_r | adv2_s;
    assign rsp_fire_s   = s2_valid_r & rsp_ready;
    assign inv_s        = gf16_inv(s1_data_r);
    assign accept_s     = |(req_valid & req_ready);

    assign rsp_valid = s2_valid_r;
    assign rsp_data  = s2_data_r;
    assign rsp_id    = s2_id_r;
    assign busy      = s1_valid_r | s2_valid_r;
    assign op_count  = op_count_r;

    // Round-robin search: first valid index at or above rr_ptr, else the
    // lowest valid index (the wrapped part of the search).
    always_comb begin
        hi_found_s = 1'b0;
        hi_idx_s   = {ID_W{1'b0}};
        lo_found_s = 1'b0;
        lo_idx_s   = {ID_W{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && !lo_found_s) begin
                lo_found_s = 1'b1;
                lo_idx_s   = ID_W'(i);
            end else begin
            end
            if (req_valid[i] && !hi_found_s && (ID_W'(i) >= rr_ptr_r)) begin
                hi_found_s = 1'b1;
                hi_idx_s   = ID_W'(i);
            end else begin
            end
        end
        grant_found_s = hi_found_s | lo_found_s;
        if (hi_found_s) begin
            grant_idx_s = hi_idx_s;
        end else begin
            grant_idx_s = lo_idx_s;
        end
    end

    // Operand mux and one-hot ready; held low during flush and reset so no
    // requester believes an operand was taken when it is being discarded.
    always_comb begin
        grant_data_s = 4'b0000;
        req_ready    = {NUM_REQ{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx_s == ID_W'(i)) begin
                grant_data_s = req_data[4*i +: 4];
                req_ready[i] = grant_found_s & can_accept_s & ~flush & reset_n;
            end else begin
            end
        end
    end

    // Pointer moves to the slot after the winner, wrapping at NUM_REQ.
    always_comb begin
        if (grant_idx_s == ID_W'(NUM_REQ - 1)) begin
            rr_next_s = {ID_W{1'b0}};
        end else begin
            rr_next_s = grant_idx_s + ID_W'(1);
        end
    end

    // Two-stage pipeline: S1 operand register, S2 result register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_valid_r <= 1'b0;
            s1_data_r  <= 4'b0000;
            s1_id_r    <= {ID_W{1'b0}};
            s2_valid_r <= 1'b0;
            s2_data_r  <= 4'b0000;
            s2_id_r    <= {ID_W{1'b0}};
        end else if (flush) begin
            s1_valid_r <= 1'b0;
            s2_valid_r <= 1'b0;
        end else begin
            if (accept_s) begin
                s1_valid_r <= 1'b1;
                s1_data_r  <= grant_data_s;
                s1_id_r    <= grant_idx_s;
            end else if (adv2_s) begin
                s1_valid_r <= 1'b0;
            end
            if (adv2_s) begin
                s2_valid_r <= 1'b1;
                s2_data_r  <= inv_s;
                s2_id_r    <= s1_id_r;
            end else if (rsp_fire_s) begin
                s2_valid_r <= 1'b0;
            end
        end
    end

    // Arbitration pointer and completed-response counter; both survive flush.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rr_ptr_r   <= {ID_W{1'b0}};
            op_count_r <= {CNT_W{1'b0}};
        end else if (!flush) begin
            if (accept_s) begin
                rr_ptr_r <= rr_next_s;
            end
            if (rsp_fire_s) begin
                op_count_r <= op_count_r + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_gf4_inv_arbiter.sv
// Directed bench for gf4_inv_arbiter with a response scoreboard: expected
// {id, inverse} entries are queued when a grant is expected and popped when
// the DUT presents a response that will handshake.
module tb_gf4_inv_arbiter;

    logic        clk;
    logic        reset_n;
    logic        flush;
    logic [3:0]  req_valid;
    logic [15:0] req_data;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic [3:0]  rsp_data;
    logic [1:0]  rsp_id;
    logic        rsp_ready;
    logic        busy;
    logic [15:0] op_count;

    int errors = 0;
    int checks = 0;
    logic [5:0] sb[$];

    gf4_inv_arbiter #(.NUM_REQ(4), .ID_W(2), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id),
        .rsp_ready(rsp_ready), .busy(busy), .op_count(op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Known inverse pairs of the normal-basis encoding.
    function automatic logic [3:0] ref_inv(input logic [3:0] x);
        case (x)
            4'b0000: return 4'b0000;
            4'b0001: return 4'b1100;
            4'b1100: return 4'b0001;
            4'b0101: return 4'b1010;
            4'b1010: return 4'b0101;
            default: return 4'bxxxx;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs at the falling edge, check the combinational
    // grant, and queue the expected result of every expected handshake.
    task automatic step(input logic rstn, input logic [3:0] v, input logic [15:0] d,
                        input logic rr, input logic fl, input logic [3:0] exp_rdy,
                        input string tag);
        @(negedge clk);
        reset_n   = rstn;
        req_valid = v;
        req_data  = d;
        rsp_ready = rr;
        flush     = fl;
        #1;
        chk(tag, 32'(req_ready), 32'(exp_rdy));
        for (int i = 0; i < 4; i++) begin
            if (v[i] && exp_rdy[i]) sb.push_back({2'(i), ref_inv(d[4*i +: 4])});
        end
    endtask

    task automatic idle(input string tag);
        step(1'b1, 4'b0000, 16'h0000, 1'b1, 1'b0, 4'b0000, tag);
    endtask

    // Response monitor: after inputs settle, a valid response with ready
    // set will handshake at the next rising edge.
    initial begin : monitor
        logic [5:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (reset_n && rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", 32'(1), 32'(0));
                end else begin
                    e = sb.pop_front();
                    chk("rsp_id", 32'(rsp_id), 32'(e[5:4]));
                    chk("rsp_data", 32'(rsp_data), 32'(e[3:0]));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0; flush = 1'b0; req_valid = 4'b0000; req_data = 16'h0000; rsp_ready = 1'b0;

        // Reset state
        for (int k = 0; k < 3; k++) step(1'b0, 4'b0000, 16'h0000, 1'b0, 1'b0, 4'b0000, "rst_ready");
        chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("rst_rsp_data",  32'(rsp_data),  32'(0));
        chk("rst_rsp_id",    32'(rsp_id),    32'(0));
        chk("rst_busy",      32'(busy),      32'(0));
        chk("rst_op_count",  32'(op_count),  32'(0));

        // Single op: 0001 -> 1100, response two edges after the accept
        step(1'b1, 4'b0001, 16'h0001, 1'b1, 1'b0, 4'b0001, "single_grant");
        idle("single_idle1");
        chk("single_busy_s1", 32'(busy), 32'(1));
        chk("single_no_rsp_yet", 32'(rsp_valid), 32'(0));
        idle("single_idle2");
        chk("single_rsp_valid", 32'(rsp_valid), 32'(1));
        chk("single_rsp_data", 32'(rsp_data), 32'hC);
        idle("single_idle3");
        chk("single_op_count", 32'(op_count), 32'(1));
        chk("single_busy_end", 32'(busy), 32'(0));

        // Round-robin: all requesters valid, one grant and one response per cycle
        step(1'b0, 4'b0000, 16'h0000, 1'b1, 1'b0, 4'b0000, "rr_reset");
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 4'b1111, 16'h5555, 1'b1, 1'b0, 4'(1 << (k % 4)), "rr_grant");
            if (k >= 2) chk("rr_rsp_every_cycle", 32'(rsp_valid), 32'(1));
        end
        idle("rr_drain1");
        idle("rr_drain2");
        idle("rr_drain3");
        chk("rr_op_count", 32'(op_count), 32'(8));

        // Backpressure from requester 2, rsp_ready low for five cycles
        step(1'b1, 4'b0100, 16'h0A00, 1'b0, 1'b0, 4'b0100, "bp_accept1");
        step(1'b1, 4'b0100, 16'h0C00, 1'b0, 1'b0, 4'b0100, "bp_accept2");
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 4'b0100, 16'h0000, 1'b0, 1'b0, 4'b0000, "bp_stalled_ready");
            chk("bp_hold_valid", 32'(rsp_valid), 32'(1));
            chk("bp_hold_data", 32'(rsp_data), 32'h5);
        end
        step(1'b1, 4'b0100, 16'h0000, 1'b1, 1'b0, 4'b0100, "bp_accept3");
        idle("bp_drain1");
        idle("bp_drain2");
        idle("bp_drain3");
        chk("bp_drained", 32'(rsp_valid), 32'(0));
        chk("bp_op_count", 32'(op_count), 32'(11));

        // Pointer hold and wrap
        step(1'b0, 4'b0000, 16'h0000, 1'b1, 1'b0, 4'b0000, "ptr_reset");
        idle("ptr_idle1");
        idle("ptr_idle2");
        step(1'b1, 4'b1000, 16'h1000, 1'b1, 1'b0, 4'b1000, "ptr_grant3");
        step(1'b1, 4'b1001, 16'hA005, 1'b1, 1'b0, 4'b0001, "ptr_grant0");
        step(1'b1, 4'b1001, 16'hA005, 1'b1, 1'b0, 4'b1000, "ptr_wrap3");
        idle("ptr_drain1");
        idle("ptr_drain2");
        idle("ptr_drain3");
        chk("ptr_op_count", 32'(op_count), 32'(3));

        // Flush with two ops in flight
        step(1'b1, 4'b0011, 16'h00C1, 1'b0, 1'b0, 4'b0001, "fl_accept0");
        step(1'b1, 4'b0010, 16'h00C1, 1'b0, 1'b0, 4'b0010, "fl_accept1");
        step(1'b1, 4'b0000, 16'h0000, 1'b0, 1'b1, 4'b0000, "fl_flush_ready");
        chk("fl_busy_before", 32'(busy), 32'(1));
        sb.delete();
        idle("fl_after");
        chk("fl_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("fl_busy", 32'(busy), 32'(0));
        chk("fl_op_count", 32'(op_count), 32'(3));
        step(1'b1, 4'b0001, 16'h0005, 1'b1, 1'b1, 4'b0000, "fl_ready_forced_low");
        idle("fl_idle");
        chk("fl_busy_empty", 32'(busy), 32'(0));
        step(1'b1, 4'b1111, 16'h5555, 1'b1, 1'b0, 4'b0100, "fl_ptr_kept");
        idle("fl_drain1");
        idle("fl_drain2");
        idle("fl_drain3");
        chk("fl_op_count_after", 32'(op_count), 32'(4));

        // Reset with two ops in flight
        step(1'b1, 4'b0011, 16'h00A5, 1'b0, 1'b0, 4'b0001, "rs_accept0");
        step(1'b1, 4'b0010, 16'h00A5, 1'b0, 1'b0, 4'b0010, "rs_accept1");
        step(1'b0, 4'b0000, 16'h0000, 1'b0, 1'b0, 4'b0000, "rs_reset_ready");
        chk("rs_busy_before", 32'(busy), 32'(1));
        chk("rs_valid_before", 32'(rsp_valid), 32'(1));
        sb.delete();
        idle("rs_after");
        chk("rs_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("rs_rsp_data", 32'(rsp_data), 32'(0));
        chk("rs_rsp_id", 32'(rsp_id), 32'(0));
        chk("rs_busy", 32'(busy), 32'(0));
        chk("rs_op_count", 32'(op_count), 32'(0));
        idle("rs_idle");

        chk("sb_empty", 32'(sb.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
